// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter for 4 agents; a grant is held while the owner's request stays high, for at most MAX_HOLD cycles.
// All outputs are registered, with one dead cycle between grants. A timed-out owner is masked until it drops its request.
module rr_hold_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_req_0,
    input  logic       i_req_1,
    input  logic       i_req_2,
    input  logic       i_req_3,
    output logic       o_gnt_0,
    output logic       o_gnt_1,
    output logic       o_gnt_2,
    output logic       o_gnt_3,
    output logic [1:0] o_gnt_id,
    output logic       o_busy,
    output logic       o_timeout
);

    localparam logic [7:0] LP_HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_last_id, w_last_id_nxt;
    logic [7:0] r_hold_cnt, w_hold_cnt_nxt;
    logic [3:0] r_mask, w_mask_nxt;
    logic [3:0] r_gnt, w_gnt_nxt;
    logic [1:0] r_gnt_id, w_gnt_id_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_timeout, w_timeout_nxt;

    logic [3:0] w_req;
    logic [3:0] w_elig;
    logic       w_found;
    logic [1:0] w_sel;
    logic [1:0] w_cand;

    assign w_req  = {i_req_3, i_req_2, i_req_1, i_req_0};
    assign w_elig = w_req & ~r_mask;

    // Search starts just after the last owner; offset 4 wraps back to the last owner itself.
    always_comb begin : pick
        w_found = 1'b0;
        w_sel   = 2'd0;
        w_cand  = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            w_cand = r_last_id + 2'(i);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin : fsm
        w_state_nxt    = r_state;
        w_last_id_nxt  = r_last_id;
        w_hold_cnt_nxt = r_hold_cnt;
        w_mask_nxt     = r_mask & w_req;
        w_gnt_nxt      = r_gnt;
        w_gnt_id_nxt   = r_gnt_id;
        w_busy_nxt     = r_busy;
        w_timeout_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt      = 4'b0001 << w_sel;
                    w_gnt_id_nxt   = w_sel;
                    w_busy_nxt     = 1'b1;
                    w_last_id_nxt  = w_sel;
                    w_hold_cnt_nxt = 8'd0;
                    w_state_nxt    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A release on the terminal edge wins over the timeout.
                if (!w_req[r_gnt_id]) begin
                    w_gnt_nxt    = 4'b0000;
                    w_gnt_id_nxt = 2'd0;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end else if (r_hold_cnt == LP_HOLD_LAST) begin
                    w_gnt_nxt            = 4'b0000;
                    w_gnt_id_nxt         = 2'd0;
                    w_busy_nxt           = 1'b0;
                    w_timeout_nxt        = 1'b1;
                    w_mask_nxt[r_gnt_id] = 1'b1;
                    w_state_nxt          = ST_IDLE;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_last_id  <= 2'd3;
            r_hold_cnt <= 8'd0;
            r_mask     <= 4'b0000;
            r_gnt      <= 4'b0000;
            r_gnt_id   <= 2'd0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_id  <= w_last_id_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_mask     <= w_mask_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
            r_busy     <= w_busy_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign o_gnt_0   = r_gnt[0];
    assign o_gnt_1   = r_gnt[1];
    assign o_gnt_2   = r_gnt[2];
    assign o_gnt_3   = r_gnt[3];
    assign o_gnt_id  = r_gnt_id;
    assign o_busy    = r_busy;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: three instances (MAX_HOLD 16, 4, 1) driven by directed steps and random requests.
module tb_rr_hold_arbiter;

    localparam int MHV [3] = '{16, 4, 1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_a [3];
    wire  [3:0] gnt_w [3];
    wire  [1:0] id_w  [3];
    wire        busy_w [3];
    wire        to_w  [3];

    int n_checks = 0;
    int n_err    = 0;

    // Reference state: who owns the resource and for how many visible cycles.
    int         m_owner [3] = '{-1, -1, -1};
    int         m_held  [3] = '{0, 0, 0};
    int         m_last  [3] = '{3, 3, 3};
    logic [3:0] m_mask  [3] = '{4'b0, 4'b0, 4'b0};
    logic       m_to    [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned MH_G = (g == 0) ? 16 : ((g == 1) ? 4 : 1);
        rr_hold_arbiter #(.MAX_HOLD(MH_G)) u_dut (
            .i_clock   (clk),
            .i_reset_n (rst_n),
            .i_req_0   (req_a[g][0]),
            .i_req_1   (req_a[g][1]),
            .i_req_2   (req_a[g][2]),
            .i_req_3   (req_a[g][3]),
            .o_gnt_0   (gnt_w[g][0]),
            .o_gnt_1   (gnt_w[g][1]),
            .o_gnt_2   (gnt_w[g][2]),
            .o_gnt_3   (gnt_w[g][3]),
            .o_gnt_id  (id_w[g]),
            .o_busy    (busy_w[g]),
            .o_timeout (to_w[g])
        );
    end

    function automatic void model_step(input int k);
        logic [3:0] r;
        logic [3:0] nm;
        int         sel;
        int         a;
        r = req_a[k];
        if (!rst_n) begin
            m_owner[k] = -1;
            m_held[k]  = 0;
            m_last[k]  = 3;
            m_mask[k]  = 4'b0;
            m_to[k]    = 1'b0;
            return;
        end
        nm       = m_mask[k] & r;
        m_to[k]  = 1'b0;
        if (m_owner[k] < 0) begin
            sel = -1;
            for (int d = 1; d <= 4; d++) begin
                a = (m_last[k] + d) % 4;
                if (sel < 0 && r[a] && !m_mask[k][a]) sel = a;
            end
            if (sel >= 0) begin
                m_owner[k] = sel;
                m_held[k]  = 1;
                m_last[k]  = sel;
            end
        end else if (!r[m_owner[k]]) begin
            m_owner[k] = -1;
        end else if (m_held[k] == MHV[k]) begin
            m_to[k]         = 1'b1;
            nm[m_owner[k]]  = 1'b1;
            m_owner[k]      = -1;
        end else begin
            m_held[k] = m_held[k] + 1;
        end
        m_mask[k] = nm;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
    end

    function automatic logic [7:0] model_out(input int k);
        logic [3:0] g;
        logic [1:0] id;
        g  = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
        id = (m_owner[k] >= 0) ? 2'(m_owner[k]) : 2'd0;
        return {g, id, (m_owner[k] >= 0), m_to[k]};
    endfunction

    function automatic logic [7:0] dut_out(input int k);
        return {gnt_w[k], id_w[k], busy_w[k], to_w[k]};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare every instance against the reference.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model_u%0d", k), dut_out(k), model_out(k));
            chk($sformatf("onehot_u%0d", k), 8'($countones(gnt_w[k]) <= 1), 8'd1);
        end
    endtask

    initial begin
        int         order [$];
        int         exp_order [5];
        int         n;
        logic       prev_busy;

        exp_order = '{0, 1, 2, 3, 0};

        // Reset with everyone requesting.
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) req_a[k] = 4'b1111;
        tick();
        tick();
        for (int k = 0; k < 3; k++) chk($sformatf("reset_u%0d", k), dut_out(k), 8'h00);

        rst_n    = 1'b1;
        req_a[0] = 4'b0001;
        req_a[1] = 4'b0000;
        req_a[2] = 4'b0000;
        tick();
        chk("first_grant", dut_out(0), {4'b0001, 2'd0, 1'b1, 1'b0});

        // Rotation: each owner lets go after three cycles of grant.
        order.push_back(0);
        for (int c = 0; c < 200 && order.size() < 5; c++) begin
            req_a[0] = 4'b1111;
            if (m_owner[0] >= 0 && m_held[0] == 3) req_a[0][m_owner[0]] = 1'b0;
            prev_busy = busy_w[0];
            tick();
            if (busy_w[0] && !prev_busy) order.push_back(int'(id_w[0]));
        end
        for (int i = 0; i < 5; i++)
            chk($sformatf("rot_order_%0d", i), (order.size() > i) ? 8'(order[i]) : 8'hFF, 8'(exp_order[i]));
        req_a[0] = 4'b0000;

        // Timeout with a lone requester on the MAX_HOLD=4 instance.
        req_a[1] = 4'b0100;
        tick();
        n = 0;
        for (int c = 0; c < 20 && gnt_w[1][2]; c++) begin
            n++;
            tick();
        end
        chk("to_len", 8'(n), 8'd4);
        chk("to_pulse", {7'd0, to_w[1]}, 8'd1);
        tick();
        chk("to_once", {7'd0, to_w[1]}, 8'd0);
        for (int c = 0; c < 4; c++) tick();
        chk("masked_idle", {7'd0, busy_w[1]}, 8'd0);
        req_a[1] = 4'b0000;
        tick();
        req_a[1] = 4'b0100;
        tick();
        chk("regrant", {4'd0, gnt_w[1]}, 8'b0100);

        // Timeout hand-off from agent 1 to agent 3.
        req_a[1] = 4'b0000;
        tick();
        req_a[1] = 4'b0010;
        tick();
        chk("handoff_own", {4'd0, gnt_w[1]}, 8'b0010);
        req_a[1] = 4'b1010;
        n = 0;
        for (int c = 0; c < 20 && gnt_w[1][1]; c++) begin
            n++;
            tick();
        end
        chk("handoff_len", 8'(n), 8'd4);
        chk("handoff_to", {7'd0, to_w[1]}, 8'd1);
        tick();
        chk("handoff_next", dut_out(1), {4'b1000, 2'd3, 1'b1, 1'b0});
        req_a[1] = 4'b0010;
        tick();
        for (int c = 0; c < 3; c++) tick();
        chk("handoff_masked", {7'd0, busy_w[1]}, 8'd0);

        // Release coinciding with the terminal count.
        req_a[1] = 4'b0000;
        tick();
        req_a[1] = 4'b0001;
        tick();
        chk("bnd_grant", {4'd0, gnt_w[1]}, 8'b0001);
        for (int c = 0; c < 3; c++) tick();
        req_a[1] = 4'b0000;
        tick();
        chk("bnd_release", dut_out(1), 8'h00);
        req_a[1] = 4'b0001;
        tick();
        chk("bnd_eligible", {4'd0, gnt_w[1]}, 8'b0001);
        req_a[1] = 4'b0000;
        tick();

        // MAX_HOLD=1: one-cycle grants, each followed by a timeout.
        for (int rep = 0; rep < 3; rep++) begin
            req_a[2] = 4'b0001;
            tick();
            chk("mh1_gnt", {4'd0, gnt_w[2]}, 8'b0001);
            tick();
            chk("mh1_to", {3'd0, gnt_w[2], to_w[2]}, 8'b0000_0001);
            tick();
            chk("mh1_masked", {7'd0, busy_w[2]}, 8'd0);
            req_a[2] = 4'b0000;
            tick();
        end

        // Reset in the middle of a grant to agent 1.
        req_a[0] = 4'b0010;
        tick();
        chk("mid_own", {4'd0, gnt_w[0]}, 8'b0010);
        tick();
        rst_n    = 1'b0;
        req_a[0] = 4'b1111;
        tick();
        chk("mid_reset", dut_out(0), 8'h00);
        rst_n = 1'b1;
        tick();
        chk("mid_restart", dut_out(0), {4'b0001, 2'd0, 1'b1, 1'b0});

        // Random requests with sticky bits and rare resets.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 3; k++)
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(0, 7) == 0) req_a[k][b] = ~req_a[k][b];
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
